hansen_mem_arbiter: RTL

//  N-master shared-RAM controller for the Hansen SoC: core, PCIe and DMA masters share one word RAM.

---
 rtl/hansen_bus_pkg.sv | 24 ++
 rtl/hansen_rr_arbiter.sv | 43 ++++
 rtl/hansen_mem_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hansen_bus_pkg.sv
// Shared definitions for the Hansen SoC bus blocks.
//  - PRIO_RR / PRIO_FIXED : arbitration mode encodings
//  - lock_state_e         : bus-lock FSM state
//  - clog2                : ceiling log2 for parameter arithmetic
package hansen_bus_pkg;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hansen_rr_arbiter.sv
// Combinational N-way arbiter.
//  Round-robin mode searches upward from ptr with wraparound; fixed mode
//  always starts at index 0, so the lowest requesting index wins.
// Ports:
//  req       in   N      request vector
//  ptr       in   IDX_W  round-robin start index (ignored in fixed mode)
//  grant     out  N      one-hot grant, zero when nothing requests
//  grant_idx out  IDX_W  index of the granted requester (0 when none)
module hansen_rr_arbiter
    import hansen_bus_pkg::*;
#(
    parameter int N         = 2,
    parameter int PRIO_MODE = PRIO_RR,
    localparam int IDX_W    = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int   start;
        int   cand;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        start     = (PRIO_MODE == PRIO_FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < N; k++) begin
            cand = start + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/hansen_mem_arbiter.sv
// Shared single-port word RAM with N requesting masters.
//  One transfer per cycle, chosen by hansen_rr_arbiter. A master may lock
//  the bus for atomic sequences; the lock is force-released after LOCK_MAX
//  cycles. Responses are registered and appear one cycle after the transfer.
// Ports:
//  clk, reset                 clock, synchronous active-high reset
//  req_valid/ready            per-master handshake; transfer = valid & ready
//  req_we/lock/addr/wdata/be  per-master request fields, packed by master
//  rsp_valid                  per-master response strobe
//  rsp_rdata, rsp_err         shared response data / out-of-range flag
//  lock_timeout               one-cycle pulse after a forced lock release
// Handshake: req_ready is combinational and one-hot (or zero); a master
//  keeps valid and all request fields stable until it sees ready.
module hansen_mem_arbiter
    import hansen_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int PRIO_MODE   = 0,
    parameter int LOCK_MAX    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            req_valid,
    output logic [NUM_MASTERS-1:0]            req_ready,
    input  logic [NUM_MASTERS-1:0]            req_we,
    input  logic [NUM_MASTERS-1:0]            req_lock,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]     req_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0]   req_be,
    output logic [NUM_MASTERS-1:0]            rsp_valid,
    output logic [DATA_W-1:0]                 rsp_rdata,
    output logic                              rsp_err,
    output logic                              lock_timeout
);

    localparam int N      = NUM_MASTERS;
    localparam int BE_W   = DATA_W / 8;
    localparam int IDX_W  = (N > 1) ? clog2(N) : 1;
    localparam int BYTE_W = clog2(BE_W);
    localparam int WORD_W = clog2(DEPTH_WORDS);
    localparam int CNT_W  = (LOCK_MAX > 1) ? clog2(LOCK_MAX) : 1;

    localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * BE_W);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(LOCK_MAX - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N - 1);

    lock_state_e        lock_state_q, lock_state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lock_timeout_q, lock_timeout_d;
    logic [N-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [N-1:0]       arb_req, arb_grant, owner_mask;
    logic [IDX_W-1:0]   arb_idx;
    logic               xfer, in_range, mem_we;
    logic               sel_we, sel_lock;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;
    logic [WORD_W-1:0]  word_idx;

    logic [DATA_W-1:0]  mem [DEPTH_WORDS];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + 1'b1;
    endfunction

    // While locked, only the owner is presented to the arbiter.
    assign owner_mask = N'(1) << owner_q;
    assign arb_req    = (lock_state_q == ST_LOCKED) ? (req_valid & owner_mask) : req_valid;

    hansen_rr_arbiter #(
        .N         (N),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Gating ready with reset drops any transfer in a reset cycle.
    assign req_ready = reset ? '0 : arb_grant;
    assign xfer      = |req_ready;

    assign sel_we    = req_we[arb_idx];
    assign sel_lock  = req_lock[arb_idx];
    assign sel_addr  = req_addr[arb_idx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[arb_idx*DATA_W +: DATA_W];
    assign sel_be    = req_be[arb_idx*BE_W +: BE_W];

    // Full-width compare so high address bits never alias into the RAM.
    assign in_range  = {1'b0, sel_addr} < ADDR_LIMIT;
    assign word_idx  = sel_addr[BYTE_W +: WORD_W];
    assign mem_we    = xfer & sel_we & in_range;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = req_ready;
        err_d       = xfer & ~in_range;
        rdata_d     = (xfer && !sel_we && in_range) ? mem[word_idx] : '0;
    end

    always_comb begin
        lock_state_d   = lock_state_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        lock_timeout_d = 1'b0;
        rr_ptr_d       = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = next_idx(arb_idx);
        end
        case (lock_state_q)
            ST_IDLE: begin
                if (xfer && sel_lock) begin
                    lock_state_d = ST_LOCKED;
                    owner_d      = arb_idx;
                    cnt_d        = '0;
                end
            end
            ST_LOCKED: begin
                cnt_d = cnt_q + 1'b1;
                // A release transfer wins over a coinciding timeout.
                if (xfer && !sel_lock) begin
                    lock_state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    lock_state_d   = ST_IDLE;
                    lock_timeout_d = 1'b1;
                    rr_ptr_d       = next_idx(owner_q);
                end
            end
            default: begin
                lock_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state_q   <= ST_IDLE;
            owner_q        <= '0;
            cnt_q          <= '0;
            rr_ptr_q       <= '0;
            lock_timeout_q <= 1'b0;
            rsp_valid_q    <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
        end else begin
            lock_state_q   <= lock_state_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_timeout_q <= lock_timeout_d;
            rsp_valid_q    <= rsp_valid_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
        end
    end

    // A response registered just before reset rises is cancelled, not delivered.
    assign rsp_valid    = reset ? '0   : rsp_valid_q;
    assign rsp_rdata    = reset ? '0   : rdata_q;
    assign rsp_err      = reset ? 1'b0 : err_q;
    assign lock_timeout = reset ? 1'b0 : lock_timeout_q;

endmodule
